// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for the instruction ROM: owns the program counter,
// registers the asynchronously read ROM word toward the decoder and handles
// start/halt, jump squash, decoder stall and one zero-overhead hardware loop.
module instr_fetch_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int LOOP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               halt,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               stall,
  input  logic               loop_cfg,
  input  logic [ADDR_W-1:0]  loop_start,
  input  logic [ADDR_W-1:0]  loop_end,
  input  logic [LOOP_W-1:0]  loop_count,
  output logic [ADDR_W-1:0]  InstrMemAddr,
  input  logic [INSTR_W-1:0] Instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_out_q, instr_out_d;
  logic                instr_valid_q, instr_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                loop_armed_q, loop_armed_d;
  logic [LOOP_W-1:0]   loop_remain_q, loop_remain_d;
  logic [ADDR_W-1:0]   loop_start_q, loop_start_d;
  logic [ADDR_W-1:0]   loop_end_q, loop_end_d;

  logic                at_loop_end;
  logic                loop_back;
  logic [ADDR_W-1:0]   next_pc;

  // Sequential address: loop back while iterations remain, else pc + 1 (wraps naturally).
  always_comb begin
    at_loop_end = loop_armed_q && (pc_q == loop_end_q);
    loop_back   = at_loop_end && (loop_remain_q != '0);
    next_pc     = loop_back ? loop_start_q : pc_q + 1'b1;
  end

  // Next-state logic: one action per RUN cycle, priority halt > jump > stall > advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = instr_valid_q;
    done_d        = 1'b0;
    loop_armed_d  = loop_armed_q;
    loop_remain_d = loop_remain_q;
    loop_start_d  = loop_start_q;
    loop_end_d    = loop_end_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          state_d       = IDLE;
          instr_valid_d = 1'b0;
          done_d        = 1'b1;
          loop_armed_d  = 1'b0;
        end else if (jump_en) begin
          // The word fetched at the old pc is dropped; the target shows up two cycles later.
          pc_d          = jump_addr;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          instr_out_d   = Instr;
          instr_valid_d = 1'b1;
          pc_d          = next_pc;
          if (loop_back) begin
            loop_remain_d = loop_remain_q - 1'b1;
          end else if (at_loop_end) begin
            loop_armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new loop configuration overrides any decrement or disarm in the same cycle;
    // the address chosen this cycle still follows the previous configuration.
    if (loop_cfg) begin
      loop_armed_d  = 1'b1;
      loop_remain_d = (loop_count == '0) ? '0 : loop_count - 1'b1;
      loop_start_d  = loop_start;
      loop_end_d    = loop_end;
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_out_q   <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      loop_armed_q  <= 1'b0;
      loop_remain_q <= '0;
      loop_start_q  <= '0;
      loop_end_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      loop_armed_q  <= loop_armed_d;
      loop_remain_q <= loop_remain_d;
      loop_start_q  <= loop_start_d;
      loop_end_q    <= loop_end_d;
    end
  end

  assign InstrMemAddr = pc_q;
  assign instr_out    = instr_out_q;
  assign instr_valid  = instr_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a directed vector table covering the main
// scenarios (reset, stall, jump squash, loops, wrap/halt, reset mid-run),
// followed by random stimulus compared against a behavioural model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt, jump_en, stall, loop_cfg;
  logic [7:0]  start_addr, jump_addr, loop_start, loop_end, loop_count;
  logic [7:0]  InstrMemAddr;
  logic [31:0] Instr, instr_out;
  logic        instr_valid, busy, done;

  int total = 0;
  int bad   = 0;

  instr_fetch_ctrl #(.ADDR_W(8), .INSTR_W(32), .LOOP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .halt(halt), .jump_en(jump_en), .jump_addr(jump_addr), .stall(stall),
    .loop_cfg(loop_cfg), .loop_start(loop_start), .loop_end(loop_end),
    .loop_count(loop_count), .InstrMemAddr(InstrMemAddr), .Instr(Instr),
    .instr_out(instr_out), .instr_valid(instr_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM contents: word n holds n.
  assign Instr = 32'(InstrMemAddr);

  typedef struct {
    int rs, st, sa, hl, je, ja, sl, cfg, ls, le, lc;
    int e_pc, e_out, e_v, e_b, e_d;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input int rs, st, sa, hl, je, ja, sl, cfg, ls, le, lc,
                              input int e_pc, e_out, e_v, e_b, e_d);
    vec_t v;
    v.rs = rs; v.st = st; v.sa = sa; v.hl = hl; v.je = je; v.ja = ja; v.sl = sl;
    v.cfg = cfg; v.ls = ls; v.le = le; v.lc = lc;
    v.e_pc = e_pc; v.e_out = e_out; v.e_v = e_v; v.e_b = e_b; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int rs, st, sa, hl, je, ja, sl, cfg, ls, le, lc);
    rst = (rs != 0); start = (st != 0); halt = (hl != 0); jump_en = (je != 0);
    stall = (sl != 0); loop_cfg = (cfg != 0);
    start_addr = 8'(sa); jump_addr = 8'(ja);
    loop_start = 8'(ls); loop_end = 8'(le); loop_count = 8'(lc);
  endtask

  task automatic check_outputs(input string tag, input int e_pc, e_out, e_v, e_b, e_d);
    chk({tag, ".pc"},    int'(InstrMemAddr), e_pc);
    chk({tag, ".instr"}, int'(instr_out),    e_out);
    chk({tag, ".valid"}, int'(instr_valid),  e_v);
    chk({tag, ".busy"},  int'(busy),         e_b);
    chk({tag, ".done"},  int'(done),         e_d);
  endtask

  // Behavioural model state
  int m_run, m_pc, m_out, m_valid, m_done, m_armed, m_remain, m_ls, m_le;

  // One clock of the fetch rules, evaluated on the pre-edge state and inputs.
  task automatic model_step(input int rs, st, sa, hl, je, ja, sl, cfg, ls, le, lc);
    if (rs != 0) begin
      m_run = 0; m_pc = 0; m_out = 0; m_valid = 0; m_done = 0;
      m_armed = 0; m_remain = 0; m_ls = 0; m_le = 0;
      return;
    end
    m_done = 0;
    if (m_run == 0) begin
      if (st != 0) begin m_pc = sa; m_run = 1; end
    end else if (hl != 0) begin
      m_run = 0; m_valid = 0; m_done = 1; m_armed = 0;
    end else if (je != 0) begin
      m_pc = ja; m_valid = 0;
    end else if (sl == 0) begin
      m_out = m_pc;
      m_valid = 1;
      if (m_armed != 0 && m_pc == m_le && m_remain > 0) begin
        m_pc = m_ls;
        m_remain = m_remain - 1;
      end else begin
        if (m_armed != 0 && m_pc == m_le) m_armed = 0;
        m_pc = (m_pc + 1) % 256;
      end
    end
    if (cfg != 0) begin
      m_armed = 1;
      m_remain = (lc > 0) ? lc - 1 : 0;
      m_ls = ls; m_le = le;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rs st sa    hl je ja    sl cfg ls    le    lc   pc    out   v b d
    // reset and start at 0x10
    tv.push_back(mk(1, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h10,0, 0, 0,    0, 0, 0,    0,    0,   8'h10, 8'h00, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h11, 8'h10, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h12, 8'h11, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h13, 8'h12, 1, 1, 0));
    // stall 3 cycles holding 0x12
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    1, 0, 0,    0,    0,   8'h13, 8'h12, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    1, 0, 0,    0,    0,   8'h13, 8'h12, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    1, 0, 0,    0,    0,   8'h13, 8'h12, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h14, 8'h13, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h15, 8'h14, 1, 1, 0));
    // jump from 0x15 to 0x40
    tv.push_back(mk(0, 0, 0,    0, 1, 8'h40,0, 0, 0,    0,    0,   8'h40, 8'h14, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h41, 8'h40, 1, 1, 0));
    // back to 0x15, then jump+stall to 0x40
    tv.push_back(mk(0, 0, 0,    0, 1, 8'h15,0, 0, 0,    0,    0,   8'h15, 8'h40, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 1, 8'h40,1, 0, 0,    0,    0,   8'h40, 8'h40, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h41, 8'h40, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h42, 8'h41, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    1, 0, 0,    0, 0, 0,    0,    0,   8'h42, 8'h41, 0, 0, 1));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h42, 8'h41, 0, 0, 0));
    // loop 0x20..0x22, count 3
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 1, 8'h20,8'h22,3,   8'h42, 8'h41, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h20,0, 0, 0,    0, 0, 0,    0,    0,   8'h20, 8'h41, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h21, 8'h20, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h22, 8'h21, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h20, 8'h22, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h21, 8'h20, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h22, 8'h21, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h20, 8'h22, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h21, 8'h20, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h22, 8'h21, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h23, 8'h22, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h24, 8'h23, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    1, 0, 0,    0, 0, 0,    0,    0,   8'h24, 8'h23, 0, 0, 1));
    // loop count 1: no repeat
    tv.push_back(mk(0, 1, 8'h20,0, 0, 0,    0, 1, 8'h20,8'h22,1,   8'h20, 8'h23, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h21, 8'h20, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h22, 8'h21, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h23, 8'h22, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h24, 8'h23, 1, 1, 0));
    // loop count 0: no repeat
    tv.push_back(mk(0, 0, 0,    1, 0, 0,    0, 0, 0,    0,    0,   8'h24, 8'h23, 0, 0, 1));
    tv.push_back(mk(0, 1, 8'h20,0, 0, 0,    0, 1, 8'h20,8'h22,0,   8'h20, 8'h23, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h21, 8'h20, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h22, 8'h21, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h23, 8'h22, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h24, 8'h23, 1, 1, 0));
    // wrap FE, FF, 00 then halt; restart at 0x30
    tv.push_back(mk(0, 0, 0,    1, 0, 0,    0, 0, 0,    0,    0,   8'h24, 8'h23, 0, 0, 1));
    tv.push_back(mk(0, 1, 8'hFE,0, 0, 0,    0, 0, 0,    0,    0,   8'hFE, 8'h23, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'hFF, 8'hFE, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h00, 8'hFF, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    1, 0, 0,    0, 0, 0,    0,    0,   8'h00, 8'hFF, 0, 0, 1));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h00, 8'hFF, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h30,0, 0, 0,    0, 0, 0,    0,    0,   8'h30, 8'hFF, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h31, 8'h30, 1, 1, 0));
    // arm loop while running, reset mid-run, start at 0x22: no loop-back
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 1, 8'h20,8'h22,5,   8'h32, 8'h31, 1, 1, 0));
    tv.push_back(mk(1, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h22,0, 0, 0,    0, 0, 0,    0,    0,   8'h22, 8'h00, 0, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h23, 8'h22, 1, 1, 0));
    tv.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,    0,   8'h24, 8'h23, 1, 1, 0));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rs, tv[i].st, tv[i].sa, tv[i].hl, tv[i].je, tv[i].ja, tv[i].sl,
            tv[i].cfg, tv[i].ls, tv[i].le, tv[i].lc);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), tv[i].e_pc, tv[i].e_out, tv[i].e_v, tv[i].e_b, tv[i].e_d);
      $display("vec %0d: pc=%02h instr=%08h valid=%0b busy=%0b done=%0b",
               i, InstrMemAddr, instr_out, instr_valid, busy, done);
    end

    // Random phase against the model, starting from reset.
    model_step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 800; n++) begin
      int rs, st, sa, hl, je, ja, sl, cfg, ls, le, lc;
      rs  = ($urandom_range(0, 99) < 2)  ? 1 : 0;
      st  = ($urandom_range(0, 99) < 15) ? 1 : 0;
      hl  = ($urandom_range(0, 99) < 4)  ? 1 : 0;
      je  = ($urandom_range(0, 99) < 8)  ? 1 : 0;
      sl  = ($urandom_range(0, 99) < 20) ? 1 : 0;
      cfg = ($urandom_range(0, 99) < 5)  ? 1 : 0;
      ls  = 8'h20 + $urandom_range(0, 3);
      le  = ls + $urandom_range(0, 4);
      lc  = $urandom_range(0, 4);
      sa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 8'h1E + $urandom_range(0, 8);
      ja  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 8'h1E + $urandom_range(0, 8);
      drive(rs, st, sa, hl, je, ja, sl, cfg, ls, le, lc);
      model_step(rs, st, sa, hl, je, ja, sl, cfg, ls, le, lc);
      @(posedge clk);
      #1;
      check_outputs($sformatf("rnd%0d", n), m_pc, m_out, m_valid, m_run, m_done);
      $display("rnd %0d: in rs=%0d st=%0d hl=%0d je=%0d sl=%0d cfg=%0d -> pc=%02h instr=%08h valid=%0b busy=%0b done=%0b",
               n, rs, st, hl, je, sl, cfg, InstrMemAddr, instr_out, instr_valid, busy, done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the WRA instruction ROM.
- Owns the program counter that drives InstrMemAddr, registers the ROM word (asynchronous read) toward the Decoder, and handles start, halt, jump squash, decoder stall and one zero-overhead hardware loop.
- Sits between the Decoder and InstrMem and replaces the free-running ProgramCnt.

Parameters:
- ADDR_W, default `InstrMemDepth (8): instruction address width.
- INSTR_W, default `InstrLength (32): instruction word width.
- LOOP_W, default 8: loop iteration count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin execution at start_addr; sampled only in IDLE.
- start_addr  in  ADDR_W  first instruction address.
- halt  in  1  from Decoder: stop fetching.
- jump_en  in  1  from Decoder: redirect fetch.
- jump_addr  in  ADDR_W  jump target.
- stall  in  1  from Decoder: hold the current output.
- loop_cfg  in  1  arm the hardware loop (any state).
- loop_start  in  ADDR_W  loop body first address.
- loop_end  in  ADDR_W  loop body last address.
- loop_count  in  LOOP_W  total body iterations.
- InstrMemAddr  out  ADDR_W  to InstrMem; equals pc.
- Instr  in  INSTR_W  from InstrMem; combinational function of InstrMemAddr.
- instr_out  out  INSTR_W  registered instruction to Decoder.
- instr_valid  out  1  instr_out holds a live instruction.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse on halt.

Behaviour:
- Reset values:
  - State IDLE; pc = 0; instr_out = 0; instr_valid = 0; busy = 0; done = 0.
  - Loop disarmed; loop_remain = 0.
  - rst overrides every other input, including mid-RUN.
- States: IDLE, RUN.
  - IDLE + start: pc <= start_addr, go to RUN. instr_valid stays 0 in that cycle.
  - IDLE without start: pc holds.
- RUN: one action per cycle, chosen by priority halt > jump_en > stall > loop > increment.
  - halt: go to IDLE; instr_valid <= 0; done <= 1 for one cycle; pc holds.
  - jump_en: pc <= jump_addr; instr_valid <= 0 (the in-flight word is squashed); instr_out holds. Takes effect even if stall is asserted. The target word appears at instr_out 2 cycles after jump_en is sampled.
  - stall: pc, instr_out and instr_valid all hold.
  - Normal advance: instr_out <= Instr; instr_valid <= 1; pc <= next_pc.
- Fetch latency: the word at address A appears on instr_out one cycle after pc = A.
- next_pc:
  - If the loop is armed, pc == loop_end and loop_remain != 0: next_pc = loop_start and loop_remain decrements.
  - Otherwise next_pc = pc + 1, modulo 2^ADDR_W. All-ones wraps to 0.
- Loop arming (loop_cfg):
  - loop_cfg sets the loop armed and loads loop_remain = loop_count - 1, saturating at 0.
  - loop_count of 0 or 1 therefore means no repeat.
  - loop_start and loop_end are latched on loop_cfg.
  - The loop disarms when an advance passes loop_end with loop_remain == 0.
- Loop interactions:
  - A jump out of the body does not disarm the loop.
  - A halt disarms the loop.
  - loop_cfg in the same cycle as a loop-back: the new configuration wins and no decrement occurs.
- busy = (state == RUN); it is registered with the state.
- start while in RUN is ignored.
- halt and jump_en are ignored in IDLE.

Test Plan:
- Reset/start: rst for 2 cycles, then start with start_addr = 0x10; ROM[n] = n.
  - Required: InstrMemAddr sequence 0x10, 0x11, 0x12…
  - instr_out = 0x10 with instr_valid = 1 on the second cycle after start; busy = 1.
- Stall: assert stall for 3 cycles while instr_out = 0x12.
  - Required: instr_out holds 0x12, instr_valid holds 1, pc holds 0x13.
  - After release, instr_out reaches 0x13 next.
- Jump squash: jump_en with jump_addr = 0x40 while pc = 0x15.
  - Required: next cycle instr_valid = 0.
  - Following cycle instr_out = 0x40 with instr_valid = 1.
  - Repeat with stall also high: identical result.
- Hardware loop: loop_cfg with loop_start = 0x20, loop_end = 0x22, loop_count = 3; run from 0x20.
  - Required: valid stream 20, 21, 22, 20, 21, 22, 20, 21, 22, 23.
  - Repeat with loop_count = 1 and loop_count = 0: stream 20, 21, 22, 23 in both cases.
- Wrap and halt: start at 0xFE, then halt two cycles later.
  - Required: pc sequence FE, FF, 00; done pulses for exactly 1 cycle; busy = 0; instr_valid = 0.
  - A later start restarts cleanly.
- Reset mid-run: rst while in RUN with the loop armed.
  - Required: all outputs return to reset values next cycle.
  - The loop is disarmed: after start at 0x22 no loop-back occurs.
